// File: rtl/asym_fifo_pkg.sv
// Shared definitions for the asymmetric-width FIFO: ratio log2 helper,
// occupancy count type and request-outcome codes.
package asym_fifo_pkg;

    // Width of the occupancy count for the default ADDR_WIDTH of 3 (0..8 read words).
    localparam int DEF_ADDR_WIDTH = 3;
    typedef logic [DEF_ADDR_WIDTH:0] count_t;

    // Request outcome codes; bit 0 = write dropped, bit 1 = read dropped.
    localparam logic [1:0] REQ_ACCEPTED     = 2'b00;
    localparam logic [1:0] REQ_DROPPED_WR   = 2'b01;
    localparam logic [1:0] REQ_DROPPED_RD   = 2'b10;
    localparam logic [1:0] REQ_DROPPED_BOTH = 2'b11;

    function automatic int log2_int(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/asym_fifo_ctrl.sv
// Pointer, occupancy and flag control for asym_fifo_n.
// Optional sticky ovf/unf outputs when ASYM_FIFO_ERR_FLAGS_EN is defined.
module asym_fifo_ctrl
    import asym_fifo_pkg::*;
#(
    parameter int RATIO      = 2,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  wr_acc,
    output logic                  rd_acc,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
`ifdef ASYM_FIFO_ERR_FLAGS_EN
    ,
    output logic                  ovf,
    output logic                  unf
`endif
);

    localparam int                  DEPTH      = 1 << ADDR_WIDTH;
    localparam int                  LOG2_RATIO = log2_int(RATIO);
    localparam logic [ADDR_WIDTH-1:0] PTR_STEP = ADDR_WIDTH'(1 << LOG2_RATIO);
    localparam logic [ADDR_WIDTH:0] CNT_STEP   = (ADDR_WIDTH+1)'(RATIO);
    localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] FULL_THR   = (ADDR_WIDTH+1)'(DEPTH - RATIO);
    localparam logic [ADDR_WIDTH:0] AF_THR     = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_THR     = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [ADDR_WIDTH:0] count_next;

    // Handshake: wr/rd are one-cycle requests. A request is accepted when the
    // registered full/empty flag allows it; a refused request is dropped, never held.
    assign wr_acc = wr && !full  && !reset;
    assign rd_acc = rd && !empty && !reset;

    always_comb begin
        count_next = count;
        if (wr_acc) count_next = count_next + CNT_STEP;
        if (rd_acc) count_next = count_next - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_STEP;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count        <= count_next;
            full         <= (count_next > FULL_THR);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_THR);
            almost_empty <= (count_next <= AE_THR);
        end
    end

`ifdef ASYM_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (wr && full)  ovf <= 1'b1;
            if (rd && empty) unf <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/asym_fifo_n.sv
// Asymmetric-width FIFO: RATIO-wide writes split into narrow FWFT reads.
// Define ASYM_FIFO_ERR_FLAGS_EN to add sticky ovf/unf outputs.
module asym_fifo_n
    import asym_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int RATIO      = 2,
    parameter int ADDR_WIDTH = 3,
    parameter int MSW_FIRST  = 1,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr,
    input  logic [RATIO*DATA_WIDTH-1:0] w_data,
    input  logic                        rd,
    output logic [DATA_WIDTH-1:0]       r_data,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [ADDR_WIDTH:0]         count
`ifdef ASYM_FIFO_ERR_FLAGS_EN
    ,
    output logic                        ovf,
    output logic                        unf
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_acc;
    logic                  rd_acc;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    asym_fifo_ctrl #(
        .RATIO      (RATIO),
        .ADDR_WIDTH (ADDR_WIDTH),
        .AF_LEVEL   (AF_LEVEL),
        .AE_LEVEL   (AE_LEVEL)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .wr_acc       (wr_acc),
        .rd_acc       (rd_acc),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef ASYM_FIFO_ERR_FLAGS_EN
        ,
        .ovf          (ovf),
        .unf          (unf)
`endif
    );

    // Slot wr_ptr+i receives the slice that must be popped i-th.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < RATIO; i++) begin
                mem[wr_ptr + ADDR_WIDTH'(i)] <=
                    w_data[((MSW_FIRST != 0) ? (RATIO - 1 - i) : i) * DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign r_data = mem[rd_ptr];

    // rd_acc is consumed by the pointer logic only; the head word is always visible.
    logic unused_rd_acc;
    assign unused_rd_acc = rd_acc;

endmodule

// File: tb/tb_asym_fifo_n.sv
// Directed bench for asym_fifo_n: a vector table plus hand-written sequences
// for wrap-around, LSW-first order, reset and optional error flags.
module tb_asym_fifo_n;
    import asym_fifo_pkg::*;

    logic       clk;
    logic       reset;
    logic       wr, rd;
    logic [7:0] w_data;
    logic [3:0] r_data;
    logic       full, empty, almost_full, almost_empty;
    logic [3:0] count;

    logic       wr_l, rd_l;
    logic [7:0] w_data_l;
    logic [3:0] r_data_l;
    logic       full_l, empty_l, af_l, ae_l;
    logic [3:0] count_l;
`ifdef ASYM_FIFO_ERR_FLAGS_EN
    logic       ovf, unf, ovf_l, unf_l;
`endif

    asym_fifo_n #(.DATA_WIDTH(4), .RATIO(2), .ADDR_WIDTH(3), .MSW_FIRST(1),
                  .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(r_data), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
`ifdef ASYM_FIFO_ERR_FLAGS_EN
        , .ovf(ovf), .unf(unf)
`endif
    );

    asym_fifo_n #(.DATA_WIDTH(4), .RATIO(2), .ADDR_WIDTH(3), .MSW_FIRST(0),
                  .AF_LEVEL(6), .AE_LEVEL(2)) dut_lsw (
        .clk(clk), .reset(reset), .wr(wr_l), .w_data(w_data_l), .rd(rd_l),
        .r_data(r_data_l), .full(full_l), .empty(empty_l),
        .almost_full(af_l), .almost_empty(ae_l), .count(count_l)
`ifdef ASYM_FIFO_ERR_FLAGS_EN
        , .ovf(ovf_l), .unf(unf_l)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic check_flags(input string tag, input logic [3:0] c, input logic f,
                               input logic e, input logic af, input logic ae);
        check({tag, ".count"},        32'(count),        32'(c));
        check({tag, ".full"},         32'(full),         32'(f));
        check({tag, ".empty"},        32'(empty),        32'(e));
        check({tag, ".almost_full"},  32'(almost_full),  32'(af));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wr = w; rd = r; w_data = d;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic step_l(input logic w, input logic r, input logic [7:0] d);
        wr_l = w; rd_l = r; w_data_l = d;
        @(posedge clk); #1;
        wr_l = 1'b0; rd_l = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] w_data;
        logic [1:0] code;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       chk_r;
        logic [3:0] r_data;
    } vec_t;

    vec_t vec[$];

    function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d,
                                input logic [1:0] code, input logic f, input logic e,
                                input logic af, input logic ae, input logic chk_r,
                                input logic [3:0] rdv);
        vec_t v;
        v.wr = w; v.rd = r; v.w_data = d; v.code = code;
        v.full = f; v.empty = e; v.af = af; v.ae = ae;
        v.chk_r = chk_r; v.r_data = rdv;
        return v;
    endfunction

    initial begin
        count_t     exp_cnt;
        logic [7:0] d;
        string      tag;

        wr = 0; rd = 0; w_data = '0;
        wr_l = 0; rd_l = 0; w_data_l = '0;
        reset = 1'b1;

        //      wr rd data   code             full emp af ae chk r
        vec.push_back(mk(1, 0, 8'hF0, REQ_ACCEPTED,   0, 0, 0, 1, 1, 4'hF));
        vec.push_back(mk(0, 1, 8'h00, REQ_ACCEPTED,   0, 0, 0, 1, 1, 4'h0));
        vec.push_back(mk(0, 1, 8'h00, REQ_ACCEPTED,   0, 1, 0, 1, 0, 4'h0));
        vec.push_back(mk(0, 1, 8'h00, REQ_DROPPED_RD, 0, 1, 0, 1, 0, 4'h0));
        vec.push_back(mk(1, 0, 8'h12, REQ_ACCEPTED,   0, 0, 0, 1, 1, 4'h1));
        vec.push_back(mk(1, 0, 8'h34, REQ_ACCEPTED,   0, 0, 0, 0, 1, 4'h1));
        vec.push_back(mk(1, 0, 8'h56, REQ_ACCEPTED,   0, 0, 1, 0, 1, 4'h1));
        vec.push_back(mk(1, 0, 8'h78, REQ_ACCEPTED,   1, 0, 1, 0, 1, 4'h1));
        vec.push_back(mk(1, 0, 8'h9A, REQ_DROPPED_WR, 1, 0, 1, 0, 1, 4'h1));
        vec.push_back(mk(0, 1, 8'h00, REQ_ACCEPTED,   1, 0, 1, 0, 1, 4'h2));
        vec.push_back(mk(1, 1, 8'hAB, REQ_DROPPED_WR, 0, 0, 1, 0, 1, 4'h3));
        vec.push_back(mk(0, 1, 8'h00, REQ_ACCEPTED,   0, 0, 0, 0, 1, 4'h4));
        vec.push_back(mk(0, 1, 8'h00, REQ_ACCEPTED,   0, 0, 0, 0, 1, 4'h5));
        vec.push_back(mk(0, 1, 8'h00, REQ_ACCEPTED,   0, 0, 0, 0, 1, 4'h6));
        vec.push_back(mk(0, 1, 8'h00, REQ_ACCEPTED,   0, 0, 0, 1, 1, 4'h7));
        vec.push_back(mk(0, 1, 8'h00, REQ_ACCEPTED,   0, 0, 0, 1, 1, 4'h8));
        vec.push_back(mk(0, 1, 8'h00, REQ_ACCEPTED,   0, 1, 0, 1, 0, 4'h0));
        vec.push_back(mk(1, 0, 8'hA5, REQ_ACCEPTED,   0, 0, 0, 1, 1, 4'hA));
        vec.push_back(mk(0, 1, 8'h00, REQ_ACCEPTED,   0, 0, 0, 1, 1, 4'h5));
        vec.push_back(mk(1, 1, 8'hC3, REQ_ACCEPTED,   0, 0, 0, 1, 1, 4'hC));
        vec.push_back(mk(0, 1, 8'h00, REQ_ACCEPTED,   0, 0, 0, 1, 1, 4'h3));
        vec.push_back(mk(0, 1, 8'h00, REQ_ACCEPTED,   0, 1, 0, 1, 0, 4'h0));

        repeat (2) @(posedge clk);
        #1;
        check_flags("reset", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef ASYM_FIFO_ERR_FLAGS_EN
        check("reset.ovf", 32'(ovf), 32'd0);
        check("reset.unf", 32'(unf), 32'd0);
`endif
        reset = 1'b0;

        exp_cnt = '0;
        for (int i = 0; i < vec.size(); i++) begin
            step(vec[i].wr, vec[i].rd, vec[i].w_data);
            if (vec[i].wr && ((vec[i].code & REQ_DROPPED_WR) == 2'b00)) exp_cnt = exp_cnt + count_t'(2);
            if (vec[i].rd && ((vec[i].code & REQ_DROPPED_RD) == 2'b00)) exp_cnt = exp_cnt - count_t'(1);
            tag = $sformatf("vec%0d", i);
            check_flags(tag, exp_cnt, vec[i].full, vec[i].empty, vec[i].af, vec[i].ae);
            if (vec[i].chk_r)
                check({tag, ".r_data"}, 32'(r_data), 32'(vec[i].r_data));
        end

        // Fill to full then drain: MSW-first order across wrapped pointers.
        for (int i = 0; i < 4; i++) begin
            d = {4'(2*i + 1), 4'(2*i + 2)};
            step(1'b1, 1'b0, d);
            exp_q.push_back(d[7:4]);
            exp_q.push_back(d[3:0]);
        end
        check("fill.full",  32'(full),  32'd1);
        check("fill.count", 32'(count), 32'd8);
        while (exp_q.size() > 0) begin
            check("drain.r_data", 32'(r_data), 32'(exp_q.pop_front()));
            step(1'b0, 1'b1, 8'h00);
        end
        check("drain.empty", 32'(empty), 32'd1);

        // Ten write-then-drain rounds to walk both pointers past the depth repeatedly.
        for (int i = 0; i < 10; i++) begin
            d = 8'(i * 29 + 7);
            step(1'b1, 1'b0, d);
            exp_q.push_back(d[7:4]);
            exp_q.push_back(d[3:0]);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("wrap%0d.r_data", i), 32'(r_data), 32'(exp_q.pop_front()));
                step(1'b0, 1'b1, 8'h00);
            end
        end
        check("wrap.empty", 32'(empty), 32'd1);

        // LSW-first instance: low nibble pops first.
        step_l(1'b1, 1'b0, 8'hF0);
        check("lsw.count",   32'(count_l),  32'd2);
        check("lsw.first",   32'(r_data_l), 32'h0);
        step_l(1'b0, 1'b1, 8'h00);
        check("lsw.second",  32'(r_data_l), 32'hF);
        check("lsw.count1",  32'(count_l),  32'd1);

        // Reset mid-operation at count 5 with a write pending.
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        step(1'b0, 1'b1, 8'h00);
        check("pre_reset.count", 32'(count), 32'd5);
        reset = 1'b1; wr = 1'b1; w_data = 8'h44;
        @(posedge clk); #1;
        reset = 1'b0; wr = 1'b0;
        check_flags("mid_reset", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00);
        check("post_reset.empty", 32'(empty), 32'd1);

`ifdef ASYM_FIFO_ERR_FLAGS_EN
        step(1'b0, 1'b1, 8'h00);
        check("unf.set",    32'(unf),   32'd1);
        check("unf.count",  32'(count), 32'd0);
        step(1'b0, 1'b0, 8'h00);
        check("unf.sticky", 32'(unf),   32'd1);
        check("ovf.clear",  32'(ovf),   32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h5A);
        check("ovf.set",    32'(ovf),   32'd1);
        check("ovf.count",  32'(count), 32'd8);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("err_reset.ovf", 32'(ovf), 32'd0);
        check("err_reset.unf", 32'(unf), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
